conv3x3_stream: RTL
===================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 convolution on a raster-order 8-bit pixel stream with programmable signed Q8.8 coefficients.
//  Two internal line buffers build each window, so the block emits one filtered pixel per interior position.
//  Sits between the pixel source and the frame writer; valid/ready on both sides.
//  Generalises the fixed 1/9 box blur to any 3x3 kernel, with pipelining and backpressure.
// PARAMETERS
//  IMG_W    640  pixels per line (>=3)
//  IMG_H    480  lines per frame (>=3)
//  DATA_W   8    pixel width in and out
//  COEF_W   16   coefficient width, signed Q8.8
//  ACC_W    DATA_W+COEF_W+4  accumulator width, signed
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       block can accept a pixel
//  in_data    in   DATA_W  pixel, unsigned
//  in_sof     in   1       first pixel of frame; qualified by in_valid&&in_ready
//  out_valid  out  1       output pixel valid
//  out_ready  in   1       sink accepts the output
//  out_data   out  DATA_W  filtered pixel, clamped to 0..2^DATA_W-1
//  out_eof    out  1       last output pixel of frame
//  coef_we    in   1       coefficient write strobe
//  coef_addr  in   4       coefficient index 0..8; k=3*r+c, r0=oldest row, c0=leftmost, 4=centre
//  coef_data  in   COEF_W  signed Q8.8 coefficient
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_eof=0, in_ready=1, counters=0, line buffers don't-care; coefs=box blur (16'h001C, centre 16'h001D).
//  - Accept on in_valid&&in_ready. col/row counters advance per accept; col wraps at IMG_W-1 (row++), row wraps at IMG_H-1 to 0.
//  - Accept with in_sof=1 forces that pixel to (0,0) (mid-frame resync); window/pipe contents of old frame are flushed (no output).
//  - Window valid when accepted pixel has row>=2 && col>=2; result is centred at (row-1,col-1). (IMG_W-2)*(IMG_H-2) outputs per frame.
//  - Pipeline: S1 window/line-buffer update, S2 nine signed multiplies pixel(zero-ext) x coef, S3 sum in ACC_W, >>8, clamp <0 ->0, >max ->max.
//  - Latency: 3 cycles accept -> out_valid, no stalls. Throughput 1 pixel/clk.
//  - Backpressure: global stall; in_ready = !(out_valid && !out_ready). Stalled stages hold; out_data/out_eof stable while out_valid&&!out_ready.
//  - out_eof=1 with output for centre (IMG_H-2, IMG_W-2).
//  - Coef write: takes effect next cycle for windows entering S2; any time legal; simultaneous with stall still writes.
//  - coef_addr>8 ignored.
// CONFIGURATION
//  CONV3X3_ROUND_EN defined: S3 adds 0x80 before >>8 (round half up). Undefined: truncate (floor toward -inf, arithmetic shift).
// STRUCTURE
//  conv_pkg: pixel_t, coef_t (signed Q8.8), COEF_BOX/COEF_BOX_C constants, NUM_TAPS=9, FRAC_BITS=8.
//  Sub-module line_buffer: depth IMG_W, width DATA_W, read-before-write on same column address; 2 instances, chained.
//  Top: counters, 3x3 window regs, coef regfile, S2/S3 pipe regs, handshake.
// TESTING (bench IMG_W=8, IMG_H=6)
//  - Flat frame of 100, default coefs, out_ready=1 -> 24 outputs all 98 (truncate) / 99 (ROUND_EN); out_eof on 24th only.
//  - Flat 255, default coefs -> all 252; first out_valid 3 cycles after accepting pixel (2,2).
//  - Coefs: centre 0x0100, others 0; ramp in_data=8*row+col -> out = 8*(row-1)+(col-1) in raster order.
//  - Laplacian (centre 0x0400, edge-adjacent 0xFF00, corners 0) on flat 50 with single 200 at (3,3) -> 255 at (3,3) centre, 0 at its 4 neighbours, 0 elsewhere.
//  - Random out_ready 50% -> no drops/dups vs model; out_data stable while stalled; in_ready low during stall.
//  - in_sof mid-frame at pixel 20, then full frame -> exactly 24 outputs of new frame; rst_n low mid-frame -> all outputs 0, coefs back to box.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared types and constants for the 3x3 streaming convolution.
//   pixel_t    : unsigned 8-bit pixel
//   coef_t     : signed Q8.8 coefficient
//   COEF_BOX   : 1/9 box-blur tap (0x001C), COEF_BOX_C centre tap (0x001D);
//                8*28 + 29 = 253, i.e. just under unity gain
//   NUM_TAPS   : taps in the 3x3 window, index k = 3*row + col, row 0 oldest
//   FRAC_BITS  : fractional bits of the coefficient format
package conv_pkg;
   localparam int unsigned NUM_TAPS   = 9;
   localparam int unsigned CENTRE_TAP = 4;
   localparam int unsigned FRAC_BITS  = 8;

   typedef logic        [7:0]  pixel_t;
   typedef logic signed [15:0] coef_t;

   localparam coef_t COEF_BOX   = 16'sh001C;
   localparam coef_t COEF_BOX_C = 16'sh001D;
endpackage

// File: rtl/line_buffer.sv
// line_buffer -- one image line of pixel storage.
//   clk      : clock, rising edge
//   i_we     : write strobe
//   i_addr   : column address (shared by read and write)
//   i_wdata  : pixel written at i_addr
//   o_rdata  : pixel currently stored at i_addr
// The read is combinational from the array, so on a write cycle o_rdata
// still shows the previous line's pixel (read-before-write). Contents are
// not reset.
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream -- streaming 3x3 convolution, raster-order pixels,
// programmable signed Q8.8 coefficients, valid/ready on both sides.
//   clk, rst_n           : clock / asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_data unsigned pixel
//   in_sof               : first pixel of frame, restarts position at (0,0)
//   out_valid/out_ready  : output handshake; out_data clamped pixel
//   out_eof              : last output of the frame
//   coef_we/addr/data    : coefficient write port, addresses above 8 ignored
// Pipeline: S1 window/line-buffer update, S2 nine products, S3 sum,
// shift and clamp. One global stall when the output is held.
// Build option CONV3X3_ROUND_EN: add 0x80 before the >>8 (round half up);
// otherwise the shift truncates toward minus infinity.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int DATA_W = 8,
   parameter int COEF_W = 16,
   parameter int ACC_W  = DATA_W + COEF_W + 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_eof,
   input  logic              coef_we,
   input  logic [3:0]        coef_addr,
   input  logic [COEF_W-1:0] coef_data
);
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic                     w_adv, w_acc, w_flush;
   logic [CW-1:0]            r_col, w_col;
   logic [RW-1:0]            r_row, w_row;
   logic [DATA_W-1:0]        w_lb0_q, w_lb1_q;
   logic [DATA_W-1:0]        r_win  [NUM_TAPS];
   logic signed [COEF_W-1:0] r_coef [NUM_TAPS];
   logic signed [PROD_W-1:0] w_prod [NUM_TAPS];
   logic signed [PROD_W-1:0] r_prod [NUM_TAPS];
   logic                     r_s1_valid, r_s1_eof, r_s2_valid, r_s2_eof;
   logic signed [ACC_W-1:0]  w_sum, w_shift;
   logic [DATA_W-1:0]        w_pix;
   logic                     r_out_valid, r_out_eof;
   logic [DATA_W-1:0]        r_out_data;

   // The only stall source is a held output; every stage freezes with it.
   assign w_adv    = !(r_out_valid && !out_ready);
   assign in_ready = w_adv;
   assign w_acc    = in_valid && w_adv;
   // An accepted SOF kills the old frame's windows still in S1/S2.
   assign w_flush  = w_acc && in_sof;
   assign w_col    = in_sof ? '0 : r_col;
   assign w_row    = in_sof ? '0 : r_row;

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_eof   = r_out_eof;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_acc) begin
         if (w_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
         end else begin
            r_col <= w_col + CW'(1);
            r_row <= w_row;
         end
      end
   end

   // lb0 holds the previous line, lb1 the one before; lb0's old pixel
   // cascades into lb1 on the same write.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
      .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(in_data), .o_rdata(w_lb0_q)
   );
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
      .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(w_lb0_q), .o_rdata(w_lb1_q)
   );

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_win[0] <= r_win[1];  r_win[1] <= r_win[2];  r_win[2] <= w_lb1_q;
         r_win[3] <= r_win[4];  r_win[4] <= r_win[5];  r_win[5] <= w_lb0_q;
         r_win[6] <= r_win[7];  r_win[7] <= r_win[8];  r_win[8] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_TAPS; k++)
            r_coef[k] <= (k == CENTRE_TAP) ? COEF_W'(COEF_BOX_C) : COEF_W'(COEF_BOX);
      end else if (coef_we && coef_addr < 4'(NUM_TAPS)) begin
         r_coef[coef_addr] <= coef_data;
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_TAPS; k++)
         w_prod[k] = PROD_W'(signed'({1'b0, r_win[k]})) * PROD_W'(r_coef[k]);
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         for (int unsigned k = 0; k < NUM_TAPS; k++) r_prod[k] <= w_prod[k];
      end
   end

   always_comb begin
      w_sum = '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
`ifdef CONV3X3_ROUND_EN
      w_sum = w_sum + ACC_W'(1 << (FRAC_BITS - 1));
`endif
      w_shift = w_sum >>> FRAC_BITS;
      if (w_shift[ACC_W-1])                 w_pix = '0;
      else if (|w_shift[ACC_W-2:DATA_W])    w_pix = '1;
      else                                  w_pix = w_shift[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_eof    <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_eof    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
         r_out_data  <= '0;
      end else if (w_adv) begin
         r_s1_valid  <= w_acc && (w_row >= RW'(2)) && (w_col >= CW'(2));
         r_s1_eof    <= (w_row == ROW_LAST) && (w_col == COL_LAST);
         r_s2_valid  <= r_s1_valid && !w_flush;
         r_s2_eof    <= r_s1_eof;
         r_out_valid <= r_s2_valid && !w_flush;
         r_out_eof   <= r_s2_valid && !w_flush && r_s2_eof;
         if (r_s2_valid) r_out_data <= w_pix;
      end
   end
endmodule
